// File: rtl/stopwatch_pkg.sv
// Shared types and widths for the stopwatch control slice.
// Used by stopwatch_ctrl, its interface and the bench.
package stopwatch_pkg;

   localparam int DIGIT_W = 4;
   localparam int DISP_W  = 2 * DIGIT_W;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_LAP   = 2'd3
   } state_t;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Datapath-facing signals of the stopwatch controller.
// master = controller side, slave = counter/decoder side.
interface stopwatch_ctrl_if;
   import stopwatch_pkg::*;

   logic [DISP_W-1:0] count_bcd;
   logic [DISP_W-1:0] disp_bcd;
   logic              run;
   logic              tick;
   logic              clr;
   logic              lap_active;
   state_t            state;

   modport master (
      input  count_bcd,
      output disp_bcd, run, tick, clr, lap_active, state
   );

   modport slave (
      output count_bcd,
      input  disp_bcd, run, tick, clr, lap_active, state
   );

endinterface

// File: rtl/sw_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter and
// a one-cycle pulse on the rising edge of the accepted level.
module sw_debounce #(
   parameter int DEBOUNCE_CYC = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

   logic          sync_1;
   logic          sync_2;
   logic          level;
   logic          level_q;
   logic [CW-1:0] cnt;

   // cnt holds how many consecutive synchronized samples disagreed with level
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_1  <= 1'b0;
         sync_2  <= 1'b0;
         level   <= 1'b0;
         level_q <= 1'b0;
         cnt     <= '0;
      end else begin
         sync_1  <= btn;
         sync_2  <= sync_1;
         level_q <= level;
         if (sync_2 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level <= sync_2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign press = level & ~level_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch start/pause/lap/clear controller with tick prescaler and display hold.
// Lap support is compiled in only when STOPWATCH_CTRL_LAP_EN is defined.
//
// state    | meaning
// ---------+---------------------------------------------
// ST_IDLE  | stopped and cleared, prescaler held at 0
// ST_RUN   | counting, display live
// ST_PAUSE | counting suspended, prescaler phase kept
// ST_LAP   | counting, display frozen on the hold register
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int TICK_DIV     = 100,
   parameter int DEBOUNCE_CYC = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             btn_ss,
   input  logic             btn_lap,
   input  logic             btn_clr,
   stopwatch_ctrl_if.master bus
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   state_t          state_q;
   state_t          state_d;
   logic            ev_ss;
   logic            ev_lap;
   logic            ev_clr;
   logic            clr_d;
   logic            clr_q;
   logic            tick_q;
   logic            run;
   logic [PW-1:0]   presc;

   sw_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_ss (
      .clk(clk), .reset(reset), .btn(btn_ss), .press(ev_ss)
   );

   sw_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_clr (
      .clk(clk), .reset(reset), .btn(btn_clr), .press(ev_clr)
   );

`ifdef STOPWATCH_CTRL_LAP_EN
   logic              lap_active;
   logic [DISP_W-1:0] hold_q;

   sw_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_lap (
      .clk(clk), .reset(reset), .btn(btn_lap), .press(ev_lap)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_q <= '0;
      end else if (state_q == ST_RUN && state_d == ST_LAP) begin
         hold_q <= bus.count_bcd;
      end
   end

   assign lap_active   = (state_q == ST_LAP);
   assign bus.disp_bcd = lap_active ? hold_q : bus.count_bcd;
`else
   logic lap_active;

   // With lap disabled the button is sampled nowhere; the AND keeps it formally read.
   assign ev_lap       = btn_lap & 1'b0;
   assign lap_active   = 1'b0;
   assign bus.disp_bcd = bus.count_bcd;
`endif

   assign run = (state_q == ST_RUN) || (state_q == ST_LAP);

   // Events not valid in a state fall through, so lower-priority ones may still win
   always_comb begin
      state_d = state_q;
      clr_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ev_clr)     clr_d   = 1'b1;
            else if (ev_ss) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (ev_ss)       state_d = ST_PAUSE;
            else if (ev_lap) state_d = ST_LAP;
         end
         ST_LAP: begin
            if (ev_ss)       state_d = ST_PAUSE;
            else if (ev_lap) state_d = ST_RUN;
         end
         ST_PAUSE: begin
            if (ev_clr) begin
               state_d = ST_IDLE;
               clr_d   = 1'b1;
            end else if (ev_ss) begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         clr_q   <= 1'b0;
         tick_q  <= 1'b0;
         presc   <= '0;
      end else begin
         state_q <= state_d;
         clr_q   <= clr_d;
         tick_q  <= run && (presc == PRESC_LAST);
         if (state_q == ST_IDLE || clr_d) begin
            presc <= '0;
         end else if (run) begin
            presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
         end
      end
   end

   assign bus.run        = run;
   assign bus.tick       = tick_q;
   assign bus.clr        = clr_q;
   assign bus.lap_active = lap_active;
   assign bus.state      = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus randomized
// button traffic compared against a behavioural model of the stopwatch rules.
module tb_stopwatch_ctrl;
   import stopwatch_pkg::*;

   localparam int TD = 4;
   localparam int DB = 4;

   logic       clk     = 1'b0;
   logic       reset   = 1'b1;
   logic       btn_ss  = 1'b0;
   logic       btn_lap = 1'b0;
   logic       btn_clr = 1'b0;
   logic [7:0] count_drv = 8'h00;

   int checks   = 0;
   int failures = 0;

   stopwatch_ctrl_if sw_if ();
   assign sw_if.count_bcd = count_drv;

   stopwatch_ctrl #(.TICK_DIV(TD), .DEBOUNCE_CYC(DB)) dut (
      .clk(clk), .reset(reset), .btn_ss(btn_ss), .btn_lap(btn_lap),
      .btn_clr(btn_clr), .bus(sw_if)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int         m_state;
   bit         m_clr;
   bit         m_tick;
   logic [7:0] m_hold;
   int         m_rc;
   bit         m_lvl  [3];
   bit         m_ev   [3];
   bit         m_p1   [3];
   bit         m_p2   [3];
   bit [15:0]  m_hist [3];

   task automatic model_reset();
      m_state = 0; m_clr = 0; m_tick = 0; m_hold = 8'h00; m_rc = 0;
      for (int b = 0; b < 3; b++) begin
         m_lvl[b] = 0; m_ev[b] = 0; m_p1[b] = 0; m_p2[b] = 0; m_hist[b] = '0;
      end
   endtask

   task automatic model_edge();
      bit raw [3];
      bit es, el, ec, run_b, flip;
      int ns;
      if (reset) return;
      raw[0] = btn_ss; raw[1] = btn_lap; raw[2] = btn_clr;
      es = m_ev[0]; el = m_ev[1]; ec = m_ev[2];
`ifndef STOPWATCH_CTRL_LAP_EN
      el = 0;
`endif
      run_b = (m_state == 1) || (m_state == 3);
      ns = m_state;
      m_clr = 0;
      case (m_state)
         0: if (ec) m_clr = 1; else if (es) ns = 1;
         1: if (es) ns = 2; else if (el) begin ns = 3; m_hold = count_drv; end
         3: if (es) ns = 2; else if (el) ns = 1;
         2: if (ec) begin ns = 0; m_clr = 1; end else if (es) ns = 1;
         default: ns = 0;
      endcase
      if (run_b) m_rc++;
      m_tick = run_b && (m_rc % TD == 0);
      if (ns == 0) m_rc = 0;
      m_state = ns;
      // accepted level flips once the last DB synchronized samples all disagree
      for (int b = 0; b < 3; b++) begin
         m_hist[b] = {m_hist[b][14:0], m_p2[b]};
         flip = 1;
         for (int i = 0; i < DB; i++) if (m_hist[b][i] == m_lvl[b]) flip = 0;
         m_ev[b] = flip && !m_lvl[b];
         if (flip) m_lvl[b] = ~m_lvl[b];
         m_p2[b] = m_p1[b];
         m_p1[b] = raw[b];
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic settle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_state(input int s, input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         step();
         if (int'(sw_if.state) == s) begin
            ok = 1;
            break;
         end
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1; model_reset();
      btn_ss = 0; btn_lap = 0; btn_clr = 0; count_drv = 8'h5A;
      #1;
      checks++; if (sw_if.state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", sw_if.state); end
      checks++; if (sw_if.run !== 1'b0) begin failures++; $display("FAIL reset_run got=%b exp=0", sw_if.run); end
      checks++; if (sw_if.tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", sw_if.tick); end
      checks++; if (sw_if.clr !== 1'b0) begin failures++; $display("FAIL reset_clr got=%b exp=0", sw_if.clr); end
      checks++; if (sw_if.lap_active !== 1'b0) begin failures++; $display("FAIL reset_lap got=%b exp=0", sw_if.lap_active); end
      checks++; if (sw_if.disp_bcd !== 8'h5A) begin failures++; $display("FAIL reset_disp got=%h exp=5a", sw_if.disp_bcd); end
      settle(2);
      reset = 1'b0;
      settle(2);
   endtask

   task automatic test_start();
      btn_ss = 1'b1;
      for (int e = 0; e <= 6; e++) begin
         step();
         if (e == 5) begin
            checks++; if (sw_if.state !== 2'd0) begin failures++; $display("FAIL start_early got=%0d exp=0", sw_if.state); end
         end
         if (e == 6) begin
            checks++; if (sw_if.state !== 2'd1) begin failures++; $display("FAIL start_edge6 got=%0d exp=1", sw_if.state); end
            checks++; if (sw_if.run !== 1'b1) begin failures++; $display("FAIL start_run got=%b exp=1", sw_if.run); end
         end
      end
      for (int n = 1; n <= 12; n++) begin
         step();
         checks++;
         if (sw_if.tick !== ((n % TD) == 0)) begin
            failures++; $display("FAIL start_tick n=%0d got=%b exp=%b", n, sw_if.tick, (n % TD) == 0);
         end
      end
      btn_ss = 1'b0;
      settle(8);
   endtask

   task automatic test_pause();
      int pc = 0, last_pre = -1, first_post = -1;
      bit seen_pause = 0, resumed = 0;
      for (int i = 0; i < 70; i++) begin
         btn_ss = (i < 8) || (i >= 20 && i < 28);
         step();
         if (sw_if.state == ST_PAUSE) begin pc++; seen_pause = 1; end
         if (seen_pause && sw_if.state == ST_RUN) resumed = 1;
         if (sw_if.tick === 1'b1) begin
            if (!resumed) last_pre = i;
            else if (first_post < 0) first_post = i;
         end
      end
      checks++; if (!seen_pause) begin failures++; $display("FAIL pause_entered got=0 exp=1"); end
      checks++; if (sw_if.state !== 2'd1) begin failures++; $display("FAIL pause_resume got=%0d exp=1", sw_if.state); end
      checks++; if (pc < 10) begin failures++; $display("FAIL pause_len got=%0d exp>=10", pc); end
      checks++;
      if (last_pre < 0 || first_post < 0 || (first_post - last_pre) != TD + pc) begin
         failures++; $display("FAIL pause_tick_gap got=%0d exp=%0d", first_post - last_pre, TD + pc);
      end
   endtask

   task automatic test_lap();
      bit ok;
      count_drv = 8'h37;
`ifdef STOPWATCH_CTRL_LAP_EN
      btn_lap = 1'b1;
      wait_state(3, 20, ok);
      checks++; if (!ok) begin failures++; $display("FAIL lap_enter got=%0d exp=3", sw_if.state); end
      checks++; if (sw_if.lap_active !== 1'b1) begin failures++; $display("FAIL lap_active got=%b exp=1", sw_if.lap_active); end
      count_drv = 8'h41;
      step();
      checks++; if (sw_if.disp_bcd !== 8'h37) begin failures++; $display("FAIL lap_hold got=%h exp=37", sw_if.disp_bcd); end
      btn_lap = 1'b0;
      settle(8);
      btn_lap = 1'b1;
      wait_state(1, 20, ok);
      checks++; if (!ok) begin failures++; $display("FAIL lap_exit got=%0d exp=1", sw_if.state); end
      checks++; if (sw_if.disp_bcd !== 8'h41) begin failures++; $display("FAIL lap_release got=%h exp=41", sw_if.disp_bcd); end
      checks++; if (sw_if.lap_active !== 1'b0) begin failures++; $display("FAIL lap_inactive got=%b exp=0", sw_if.lap_active); end
`else
      btn_lap = 1'b1;
      wait_state(3, 15, ok);
      checks++; if (ok || sw_if.state !== 2'd1) begin failures++; $display("FAIL lap_ignored got=%0d exp=1", sw_if.state); end
      checks++; if (sw_if.lap_active !== 1'b0) begin failures++; $display("FAIL lap_tied got=%b exp=0", sw_if.lap_active); end
      checks++; if (sw_if.disp_bcd !== 8'h37) begin failures++; $display("FAIL lap_disp got=%h exp=37", sw_if.disp_bcd); end
`endif
      btn_lap = 1'b0;
      settle(8);
   endtask

   task automatic test_simul();
      bit ok;
      int nclr;
      btn_ss = 1'b1;
      wait_state(2, 20, ok);
      checks++; if (!ok) begin failures++; $display("FAIL simul_to_pause got=%0d exp=2", sw_if.state); end
      btn_ss = 1'b0;
      settle(8);
      nclr = 0;
      btn_ss = 1'b1; btn_clr = 1'b1;
      for (int i = 0; i < 15; i++) begin step(); if (sw_if.clr === 1'b1) nclr++; end
      checks++; if (nclr != 1) begin failures++; $display("FAIL simul_pause_clr got=%0d exp=1", nclr); end
      checks++; if (sw_if.state !== 2'd0) begin failures++; $display("FAIL simul_pause_state got=%0d exp=0", sw_if.state); end
      btn_ss = 1'b0; btn_clr = 1'b0;
      settle(8);
      btn_ss = 1'b1;
      wait_state(1, 20, ok);
      checks++; if (!ok) begin failures++; $display("FAIL simul_to_run got=%0d exp=1", sw_if.state); end
      btn_ss = 1'b0;
      settle(8);
      nclr = 0;
      btn_ss = 1'b1; btn_clr = 1'b1;
      for (int i = 0; i < 15; i++) begin step(); if (sw_if.clr === 1'b1) nclr++; end
      checks++; if (nclr != 0) begin failures++; $display("FAIL simul_run_clr got=%0d exp=0", nclr); end
      checks++; if (sw_if.state !== 2'd2) begin failures++; $display("FAIL simul_run_state got=%0d exp=2", sw_if.state); end
      btn_ss = 1'b0; btn_clr = 1'b0;
      settle(8);
   endtask

   task automatic test_glitch();
      int changes = 0;
      logic [1:0] prev;
      prev = sw_if.state;
      btn_ss = 1'b1;
      settle(2);
      btn_ss = 1'b0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (sw_if.state !== prev) changes++;
         prev = sw_if.state;
      end
      checks++; if (changes != 0 || sw_if.state !== 2'd2) begin failures++; $display("FAIL glitch_reject changes=%0d state=%0d exp changes=0 state=2", changes, sw_if.state); end
      btn_ss = 1'b1;
      for (int i = 0; i < 50; i++) begin
         step();
         if (sw_if.state !== prev) changes++;
         prev = sw_if.state;
      end
      checks++; if (changes != 1) begin failures++; $display("FAIL held_one_event got=%0d exp=1", changes); end
      checks++; if (sw_if.state !== 2'd1) begin failures++; $display("FAIL held_state got=%0d exp=1", sw_if.state); end
      btn_ss = 1'b0;
      settle(8);
   endtask

   task automatic test_reset_mid_run();
      bit seen = 0;
      int nclr = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (sw_if.tick === 1'b1) begin seen = 1; break; end
      end
      checks++; if (!seen) begin failures++; $display("FAIL midreset_tick_wait got=0 exp=1"); end
      reset = 1'b1; model_reset();
      #1;
      checks++; if (sw_if.run !== 1'b0) begin failures++; $display("FAIL midreset_run got=%b exp=0", sw_if.run); end
      checks++; if (sw_if.tick !== 1'b0) begin failures++; $display("FAIL midreset_tick got=%b exp=0", sw_if.tick); end
      checks++; if (sw_if.clr !== 1'b0) begin failures++; $display("FAIL midreset_clr got=%b exp=0", sw_if.clr); end
      checks++; if (sw_if.state !== 2'd0) begin failures++; $display("FAIL midreset_state got=%0d exp=0", sw_if.state); end
      step();
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin step(); if (sw_if.clr === 1'b1) nclr++; end
      checks++; if (nclr != 0) begin failures++; $display("FAIL midreset_no_clr got=%0d exp=0", nclr); end
      checks++; if (sw_if.state !== 2'd0) begin failures++; $display("FAIL midreset_idle got=%0d exp=0", sw_if.state); end
   endtask

   task automatic test_random();
      bit raw  [3];
      int left [3];
      logic [7:0] exp_disp;
      reset = 1'b1; model_reset();
      btn_ss = 0; btn_lap = 0; btn_clr = 0;
      settle(2);
      reset = 1'b0;
      for (int b = 0; b < 3; b++) begin raw[b] = 0; left[b] = 0; end
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int b = 0; b < 3; b++) begin
            if (left[b] > 0) begin
               left[b]--;
            end else if (raw[b]) begin
               raw[b] = 0; left[b] = int'($urandom_range(1, 15));
            end else if ($urandom_range(0, 7) == 0) begin
               raw[b] = 1; left[b] = int'($urandom_range(0, 13));
            end
         end
         btn_ss = raw[0]; btn_lap = raw[1];
         btn_clr = (raw[2] && $urandom_range(0, 1) == 0) ? 1'b1 : raw[2];
         if ($urandom_range(0, 3) == 0) count_drv = 8'($urandom);
         step();
         exp_disp = (m_state == 3) ? m_hold : count_drv;
         checks++; if (sw_if.state !== 2'(m_state)) begin failures++; $display("FAIL rand_state cyc=%0d got=%0d exp=%0d", cyc, sw_if.state, m_state); end
         checks++; if (sw_if.run !== (m_state == 1 || m_state == 3)) begin failures++; $display("FAIL rand_run cyc=%0d got=%b", cyc, sw_if.run); end
         checks++; if (sw_if.tick !== m_tick) begin failures++; $display("FAIL rand_tick cyc=%0d got=%b exp=%b", cyc, sw_if.tick, m_tick); end
         checks++; if (sw_if.clr !== m_clr) begin failures++; $display("FAIL rand_clr cyc=%0d got=%b exp=%b", cyc, sw_if.clr, m_clr); end
         checks++; if (sw_if.lap_active !== (m_state == 3)) begin failures++; $display("FAIL rand_lap cyc=%0d got=%b", cyc, sw_if.lap_active); end
         checks++; if (sw_if.disp_bcd !== exp_disp) begin failures++; $display("FAIL rand_disp cyc=%0d got=%h exp=%h", cyc, sw_if.disp_bcd, exp_disp); end
      end
      btn_ss = 0; btn_lap = 0; btn_clr = 0;
   endtask

   initial begin
      test_reset();
      test_start();
      test_pause();
      test_lap();
      test_simul();
      test_glitch();
      test_reset_mid_run();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired before summary");
      $fatal(1, "watchdog");
   end

endmodule
